// File: rtl/nios2_system_sysid_arb.sv
// Two-master round-robin read arbiter in front of a shared system-ID slave.
// Each accepted read runs IDLE -> CAPTURE -> RESP, so data returns two cycles after acceptance.
module nios2_system_sysid_arb #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StCapture, StResp} state_e;

    state_e            state_q, state_d;
    logic              rr_last_q;
    logic              gnt_idx_q;
    logic              s_address_q;
    logic [DATA_W-1:0] resp_q;
    logic              gnt_sel;
    logic              idle_view;
    logic              accept;

    // On contention the master that did not win last time gets the grant.
    always_comb begin
        gnt_sel = 1'b0;
        if (m0_read && m1_read) begin
            gnt_sel = ~rr_last_q;
        end else begin
            gnt_sel = m1_read;
        end
    end

    // Reset makes waitrequest look like IDLE, but nothing is latched while it is high.
    assign idle_view = (state_q == StIdle) || reset;
    assign accept    = (state_q == StIdle) && !reset && (m0_read || m1_read);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StCapture;
            StCapture: state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        m0_waitrequest   = m0_read && !(idle_view && !gnt_sel);
        m1_waitrequest   = m1_read && !(idle_view && gnt_sel);
        m0_readdatavalid = (state_q == StResp) && !reset && !gnt_idx_q;
        m1_readdatavalid = (state_q == StResp) && !reset && gnt_idx_q;
        m0_readdata      = m0_readdatavalid ? resp_q : '0;
        m1_readdata      = m1_readdatavalid ? resp_q : '0;
        busy             = (state_q != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q   <= 1'b1;
            gnt_idx_q   <= 1'b0;
            s_address_q <= 1'b0;
            resp_q      <= '0;
        end else if (accept) begin
            rr_last_q   <= gnt_sel;
            gnt_idx_q   <= gnt_sel;
            s_address_q <= gnt_sel ? m1_address : m0_address;
        end else if (state_q == StCapture) begin
            resp_q <= s_readdata;
        end
    end

    assign s_address = s_address_q;

endmodule

// File: tb/tb_nios2_system_sysid_arb.sv
// Directed bench for the sysid arbiter: inputs change just after the rising edge,
// outputs are checked on the falling edge of the same cycle.
module tb_nios2_system_sysid_arb;

    localparam logic [31:0] Id1 = 32'h60994B90;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_address, m0_read, m0_waitrequest, m0_readdatavalid;
    logic        m1_address, m1_read, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_address;
    logic [31:0] s_readdata;
    logic        busy;

    int checks = 0;
    int passes = 0;

    nios2_system_sysid_arb #(.DATA_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_readdata       (s_readdata),
        .busy             (busy)
    );

    // Slave model: address 0 -> 0, address 1 -> system ID.
    assign s_readdata = s_address ? Id1 : 32'h0;

    always #5 clock = ~clock;

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int  cnt0, cnt1, both, alt_err, data_err;
        logic last_v, seen;

        reset = 1'b1;
        m0_read = 1'b1; m0_address = 1'b0;
        m1_read = 1'b0; m1_address = 1'b0;
        next();
        mid();
        chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
        chk("rst_m1_wait", {31'b0, m1_waitrequest}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valids", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        chk("rst_m0_data", m0_readdata, 32'd0);
        chk("rst_m1_data", m1_readdata, 32'd0);
        chk("rst_s_addr", {31'b0, s_address}, 32'd0);
        m0_read = 1'b0;
        next();
        reset = 1'b0;
        mid();
        chk("rst_no_grant_busy", {31'b0, busy}, 32'd0);
        next();

        // Single read of address 1 by master 0.
        m0_read = 1'b1; m0_address = 1'b1;
        mid();
        chk("t1_accept_wait", {31'b0, m0_waitrequest}, 32'd0);
        chk("t1_idle_busy", {31'b0, busy}, 32'd0);
        next();
        m0_read = 1'b0;
        mid();
        chk("t1_busy_t1", {31'b0, busy}, 32'd1);
        chk("t1_valid_t1", {31'b0, m0_readdatavalid}, 32'd0);
        chk("t1_data_t1", m0_readdata, 32'd0);
        chk("t1_s_addr", {31'b0, s_address}, 32'd1);
        next();
        mid();
        chk("t1_valid_t2", {31'b0, m0_readdatavalid}, 32'd1);
        chk("t1_data_t2", m0_readdata, Id1);
        chk("t1_m1_valid_t2", {31'b0, m1_readdatavalid}, 32'd0);
        chk("t1_busy_t2", {31'b0, busy}, 32'd1);
        next();
        mid();
        chk("t1_valid_t3", {31'b0, m0_readdatavalid}, 32'd0);
        chk("t1_busy_t3", {31'b0, busy}, 32'd0);

        // Simultaneous requests straight after reset: master 0 first.
        reset = 1'b1;
        next();
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 1'b0;
        m1_read = 1'b1; m1_address = 1'b1;
        mid();
        chk("t2_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
        chk("t2_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
        next();
        m0_read = 1'b0;
        mid();
        chk("t2_m1_wait_t1", {31'b0, m1_waitrequest}, 32'd1);
        next();
        mid();
        chk("t2_m0_valid_t2", {31'b0, m0_readdatavalid}, 32'd1);
        chk("t2_m0_data_t2", m0_readdata, 32'd0);
        chk("t2_m1_wait_t2", {31'b0, m1_waitrequest}, 32'd1);
        chk("t2_m1_valid_t2", {31'b0, m1_readdatavalid}, 32'd0);
        next();
        mid();
        chk("t2_m1_accept_t3", {31'b0, m1_waitrequest}, 32'd0);
        chk("t2_m0_valid_t3", {31'b0, m0_readdatavalid}, 32'd0);
        next();
        m1_read = 1'b0;
        mid();
        chk("t2_busy_t4", {31'b0, busy}, 32'd1);
        next();
        mid();
        chk("t2_m1_valid_t5", {31'b0, m1_readdatavalid}, 32'd1);
        chk("t2_m1_data_t5", m1_readdata, Id1);
        chk("t2_m0_valid_t5", {31'b0, m0_readdatavalid}, 32'd0);
        next();
        mid();
        chk("t2_busy_t6", {31'b0, busy}, 32'd0);
        next();

        // Continuous contention for 30 cycles; m1 last granted so m0 starts.
        m0_read = 1'b1; m0_address = 1'b1;
        m1_read = 1'b1; m1_address = 1'b0;
        cnt0 = 0; cnt1 = 0; both = 0; alt_err = 0; data_err = 0;
        last_v = 1'b1; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mid();
            if (m0_readdatavalid && m1_readdatavalid) both++;
            if (m0_readdatavalid) begin
                cnt0++;
                if (seen && !last_v) alt_err++;
                if (!seen) seen = 1'b1;
                last_v = 1'b0;
                if (m0_readdata !== Id1) data_err++;
            end else if (m1_readdatavalid) begin
                cnt1++;
                if (!seen || last_v) alt_err++;
                last_v = 1'b1;
                if (m1_readdata !== 32'd0) data_err++;
            end
            next();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        chk("t3_m0_responses", cnt0, 32'd5);
        chk("t3_m1_responses", cnt1, 32'd5);
        chk("t3_both_valid", both, 32'd0);
        chk("t3_alternation", alt_err, 32'd0);
        chk("t3_data", data_err, 32'd0);
        mid();
        chk("t3_busy_end", {31'b0, busy}, 32'd0);
        next();

        // Reset one cycle after an accept aborts the transaction.
        m0_read = 1'b1; m0_address = 1'b1;
        mid();
        chk("t4_accept_wait", {31'b0, m0_waitrequest}, 32'd0);
        next();
        m0_read = 1'b0;
        reset = 1'b1;
        mid();
        chk("t4_valid_in_rst", {31'b0, m0_readdatavalid}, 32'd0);
        next();
        reset = 1'b0;
        mid();
        chk("t4_valid_t2", {31'b0, m0_readdatavalid}, 32'd0);
        chk("t4_busy_t2", {31'b0, busy}, 32'd0);
        next();
        mid();
        chk("t4_valids_t3", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        next();

        // m1 requests during an m0 transaction, then withdraws before IDLE.
        m0_read = 1'b1; m0_address = 1'b0;
        mid();
        chk("t5_m0_accept", {31'b0, m0_waitrequest}, 32'd0);
        next();
        m0_read = 1'b0;
        m1_read = 1'b1; m1_address = 1'b1;
        mid();
        chk("t5_m1_wait_cap", {31'b0, m1_waitrequest}, 32'd1);
        chk("t5_busy_cap", {31'b0, busy}, 32'd1);
        next();
        mid();
        chk("t5_m1_wait_resp", {31'b0, m1_waitrequest}, 32'd1);
        chk("t5_m0_valid", {31'b0, m0_readdatavalid}, 32'd1);
        m1_read = 1'b0;
        next();
        mid();
        chk("t5_no_grant", {31'b0, busy}, 32'd0);
        chk("t5_m1_valid_a", {31'b0, m1_readdatavalid}, 32'd0);
        next();
        mid();
        chk("t5_m1_valid_b", {31'b0, m1_readdatavalid}, 32'd0);
        next();

        // Pointer still names m0 as last granted, so m1 wins this contention.
        m0_read = 1'b1; m0_address = 1'b1;
        m1_read = 1'b1; m1_address = 1'b1;
        mid();
        chk("t5_rr_m1_wait", {31'b0, m1_waitrequest}, 32'd0);
        chk("t5_rr_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
        next();
        m1_read = 1'b0;
        mid();
        chk("t5_m0_held_cap", {31'b0, m0_waitrequest}, 32'd1);
        next();
        mid();
        chk("t5_m1_valid_c", {31'b0, m1_readdatavalid}, 32'd1);
        chk("t5_m1_data_c", m1_readdata, Id1);
        chk("t5_m0_data_idle", m0_readdata, 32'd0);
        chk("t5_m0_held_resp", {31'b0, m0_waitrequest}, 32'd1);
        next();
        mid();
        chk("t5_m0_accept_late", {31'b0, m0_waitrequest}, 32'd0);
        next();
        m0_read = 1'b0;
        mid();
        chk("t5_busy_late", {31'b0, busy}, 32'd1);
        next();
        mid();
        chk("t5_m0_valid_late", {31'b0, m0_readdatavalid}, 32'd1);
        chk("t5_m0_data_late", m0_readdata, Id1);
        next();

        // m1 raised in CAPTURE is held off until IDLE, then served two cycles later.
        m0_read = 1'b1; m0_address = 1'b0;
        mid();
        next();
        m0_read = 1'b0;
        m1_read = 1'b1; m1_address = 1'b1;
        mid();
        chk("t6_wait_cap", {31'b0, m1_waitrequest}, 32'd1);
        next();
        mid();
        chk("t6_wait_resp", {31'b0, m1_waitrequest}, 32'd1);
        next();
        mid();
        chk("t6_accept_idle", {31'b0, m1_waitrequest}, 32'd0);
        next();
        m1_read = 1'b0;
        mid();
        chk("t6_valid_t1", {31'b0, m1_readdatavalid}, 32'd0);
        next();
        mid();
        chk("t6_valid_t2", {31'b0, m1_readdatavalid}, 32'd1);
        chk("t6_data_t2", m1_readdata, Id1);
        next();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nios2_system_sysid_arb.md
NIOS2_SYSTEM_SYSID_ARB -- requirements
Module: nios2_system_sysid_arb

Interface
REQ-001 Parameter: DATA_W, default 32, width of slave and master readdata.
REQ-002 Ports, clock and reset first:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-003 Master 0 ports:
- m0_address  in  1  word address.
- m0_read  in  1  read request.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DATA_W  response data.
- m0_readdatavalid  out  1  response strobe.
REQ-004 Master 1 ports: m1_address, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid, identical to master 0.
REQ-005 Shared slave ports:
- s_address  out  1  registered address to the shared system-ID slave.
- s_readdata  in  DATA_W  combinational slave read data.
REQ-006 Status port: busy  out  1  high in any state other than IDLE.
REQ-007 Clocking and reset are fixed: one clock, and the reset is synchronous and active-high.

Function
REQ-008 FSM states: IDLE, CAPTURE, RESP. IDLE->CAPTURE on grant; CAPTURE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-009 Grant is given only in IDLE. It goes to the single requester whose mX_read=1.
REQ-010 When both masters request in the same IDLE cycle, grant goes to the master not granted last. This is a round-robin pointer.
REQ-011 Acceptance: mX_waitrequest = mX_read AND NOT (state==IDLE AND grant==X).
- The granted master sees waitrequest=0 in the accept cycle.
- Every other requesting master sees waitrequest=1.
- Any master with mX_read=0 sees waitrequest=0.
REQ-012 In the accept cycle:
- Latch the granted master's address into s_address.
- Latch the grant index.
- Update the round-robin pointer to the granted index.
REQ-013 CAPTURE: register s_readdata, sampled with the latched s_address, into the response register.
REQ-014 RESP: assert readdatavalid for exactly one cycle, on the granted master only.
- That master's readdata equals the response register.
- The other master's readdatavalid=0.
REQ-015 mX_readdata SHALL be 0 whenever mX_readdatavalid=0.
REQ-016 Latency: request accepted at cycle T gives readdatavalid at T+2. The next grant is possible no earlier than T+3.
REQ-017 Data is passed through bit-exact. No arithmetic and no width change is applied.
REQ-018 A master that drops mX_read while waitrequest=1 is not served, and no response is produced for it.
REQ-019 A master that holds mX_read after its own response is re-arbitrated in the following IDLE cycle like any new request.
REQ-020 Requests arriving in CAPTURE or RESP are stalled with waitrequest=1 and are not lost.
REQ-021 Starvation bound: under continuous contention, each master is granted at least every 6 cycles.

Reset
REQ-022 Reset values:
- state=IDLE
- round-robin pointer = master 1 last-granted, so master 0 wins first contention
- s_address=0, response register=0, busy=0
- both readdatavalid=0, both readdata=0
REQ-023 Reset asserted in CAPTURE or RESP aborts the transaction.
- No readdatavalid is issued for it, including in the cycle after reset deasserts.
REQ-024 While reset=1, waitrequest follows REQ-011 with state=IDLE, but no grant is latched.

Verification
Bench slave model: address 0 returns 0x00000000; address 1 returns 0x60994B90.
REQ-025 Single read: m0_read=1, m0_address=1 at cycle T.
- m0_waitrequest=0 at T.
- m0_readdatavalid=1 with m0_readdata=0x60994B90 at T+2 only.
- busy high during T+1..T+2.
REQ-026 Simultaneous requests after reset: m0 address 0 and m1 address 1, both at T.
- m0 is served first with 0x00000000 at T+2.
- m1 is accepted at T+3 and receives 0x60994B90 at T+5.
REQ-027 Continuous contention for 30 cycles: grants alternate m0, m1, m0, ...
- Each master gets exactly 5 responses.
- There is never a cycle with both readdatavalid high.
REQ-028 Reset pulse at T+1 after an accept at T: no readdatavalid at T+2 or T+3, busy=0 at T+2.
REQ-029 Request withdrawal: m1 raises read during a master-0 transaction and drops it before IDLE.
- m1 receives no response.
- The round-robin pointer is unchanged by m1.
REQ-030 Hold-off check: m1_read asserted in CAPTURE is held with waitrequest=1 until the next IDLE, then accepted with latency per REQ-016.
